// File: rtl/result_scan_display_pkg.sv
// Shared definitions for the result scan display.
//   state_e    capture FSM encoding
//   SEG_DASH   glyph shown while no result has been captured
//   SEG_BLANK  all segments off (blanked leading zero)
//   RESULT_W   width of the accelerator result
package result_scan_display_pkg;

   typedef enum logic [1:0] {
      StWaitDone = 2'd0,
      StAck      = 2'd1,
      StWaitClr  = 2'd2
   } state_e;

   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam int unsigned RESULT_W = 18;

endpackage

// File: rtl/result_scan_display_hex_seg_decode.sv
// Combinational hex to 7-segment decoder, active-low, segment order {g,f,e,d,c,b,a}.
//   hex  in   4  nibble to display
//   seg  out  7  active-low segment pattern
module hex_seg_decode
   import result_scan_display_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'b1000000;
      case (hex)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/result_scan_display.sv
// Captures the exponent accelerator result on done, acknowledges it with a one-cycle
// read pulse, and shows result[17:4] on a 4-digit multiplexed common-anode display.
//   clk    in   1   system clock
//   rst    in   1   synchronous active-high reset
//   done   in   1   result-available level
//   ready  in   1   accelerator idle flag (does not change the display)
//   q_in   in   18  result; bits [3:0] are fraction and not displayed
//   read   out  1   one-cycle acknowledge
//   valid  out  1   a result has been captured since reset
//   seg    out  7   active-low segments {g..a}
//   an     out  4   active-low one-hot digit enable, an[0] rightmost
module result_scan_display
   import result_scan_display_pkg::*;
#(
   parameter int unsigned REFRESH_W = 16,
   parameter bit          BLANK_LZ  = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                done,
   input  logic                ready,
   input  logic [RESULT_W-1:0] q_in,
   output logic                read,
   output logic                valid,
   output logic [6:0]          seg,
   output logic [3:0]          an
);

   state_e                state_q, state_d;
   logic                  capture;
   logic [RESULT_W-1:0]   result_q;
   logic                  valid_q, read_q;
   logic [REFRESH_W-1:0]  presc_q;
   logic [1:0]            idx_q, idx_nxt;
   logic [3:0]            an_q, an_nxt;
   logic [6:0]            seg_q, seg_nxt, glyph;
   logic [3:0]            d0, d1, d2, d3, nib;
   logic                  lz, wrap;

   // ready and the fraction bits have no visible effect on the display.
   logic unused_ok;
   assign unused_ok = ^{ready, result_q[3:0]};

   // Capture FSM: WAIT_CLR holds off until done drops so a held result is taken once.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      unique case (state_q)
         StWaitDone: begin
            if (done) begin
               capture = 1'b1;
               state_d = StAck;
            end
         end
         StAck:     state_d = StWaitClr;
         StWaitClr: if (!done) state_d = StWaitDone;
         default:   state_d = StWaitDone;
      endcase
   end

   assign d0 = result_q[7:4];
   assign d1 = result_q[11:8];
   assign d2 = result_q[15:12];
   assign d3 = {2'b00, result_q[17:16]};

   assign wrap    = &presc_q;
   assign idx_nxt = idx_q + 2'd1;
   assign an_nxt  = ~(4'b0001 << idx_nxt);

   // Digit mux and leading-zero detect for the digit about to be shown.
   always_comb begin
      nib = d0;
      lz  = 1'b0;
      unique case (idx_nxt)
         2'd0: nib = d0;
         2'd1: begin
            nib = d1;
            lz  = (d3 == 4'd0) && (d2 == 4'd0) && (d1 == 4'd0);
         end
         2'd2: begin
            nib = d2;
            lz  = (d3 == 4'd0) && (d2 == 4'd0);
         end
         2'd3: begin
            nib = d3;
            lz  = (d3 == 4'd0);
         end
         default: nib = d0;
      endcase
   end

   hex_seg_decode u_dec (
      .hex (nib),
      .seg (glyph)
   );

   always_comb begin
      seg_nxt = glyph;
      if (!valid_q) begin
         seg_nxt = SEG_DASH;
      end else if (BLANK_LZ && lz) begin
         seg_nxt = SEG_BLANK;
      end
   end

   // an and seg load on the same edge so a slot never shows a stale glyph.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StWaitDone;
         read_q   <= 1'b0;
         valid_q  <= 1'b0;
         result_q <= '0;
         presc_q  <= '0;
         idx_q    <= 2'd0;
         an_q     <= 4'b1110;
         seg_q    <= SEG_DASH;
      end else begin
         state_q <= state_d;
         read_q  <= (state_d == StAck);
         if (capture) begin
            result_q <= q_in;
            valid_q  <= 1'b1;
         end
         presc_q <= presc_q + 1'b1;
         if (wrap) begin
            idx_q <= idx_nxt;
            an_q  <= an_nxt;
            seg_q <= seg_nxt;
         end
      end
   end

   assign read  = read_q;
   assign valid = valid_q;
   assign seg   = seg_q;
   assign an    = an_q;

endmodule

// File: tb/tb_result_scan_display.sv
// Directed bench for result_scan_display with a fast scan (REFRESH_W=2).
// Two instances share stimulus: one without and one with leading-zero blanking.
module tb_result_scan_display;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        done = 1'b0;
   logic        ready = 1'b1;
   logic [17:0] q_in = '0;
   logic        read0, valid0, read1, valid1;
   logic [6:0]  seg0, seg1;
   logic [3:0]  an0, an1;

   int checks = 0;
   int failures = 0;

   localparam logic [6:0] DASH = 7'b0111111;

   always #5 clk = ~clk;

   result_scan_display #(.REFRESH_W(2), .BLANK_LZ(1'b0)) dut0 (
      .clk   (clk),
      .rst   (rst),
      .done  (done),
      .ready (ready),
      .q_in  (q_in),
      .read  (read0),
      .valid (valid0),
      .seg   (seg0),
      .an    (an0)
   );

   result_scan_display #(.REFRESH_W(2), .BLANK_LZ(1'b1)) dut1 (
      .clk   (clk),
      .rst   (rst),
      .done  (done),
      .ready (ready),
      .q_in  (q_in),
      .read  (read1),
      .valid (valid1),
      .seg   (seg1),
      .an    (an1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int an_idx(input logic [3:0] a);
      case (a)
         4'b1110: return 0;
         4'b1101: return 1;
         4'b1011: return 2;
         4'b0111: return 3;
         default: return -1;
      endcase
   endfunction

   // One full scan; e packs {d3,d2,d1,d0} expected glyphs.
   task automatic scan_check(input string tag, input logic [27:0] e0, input logic [27:0] e1);
      int k;
      for (int i = 0; i < 16; i++) begin
         tick();
         k = an_idx(an0);
         if (k < 0) check({tag, "_an0"}, {28'd0, an0}, 32'hE);
         else check({tag, "_seg0"}, {25'd0, seg0}, {25'd0, e0[k*7 +: 7]});
         k = an_idx(an1);
         if (k < 0) check({tag, "_an1"}, {28'd0, an1}, 32'hE);
         else check({tag, "_seg1"}, {25'd0, seg1}, {25'd0, e1[k*7 +: 7]});
      end
   endtask

   initial begin
      logic [3:0] exp_an;
      logic [3:0] pa;
      logic [6:0] ps;
      int gap, changes;
      bit seen;

      // 1 Reset
      rst = 1'b1;
      done = 1'b0;
      tick(); tick(); tick();
      check("rst_read",  {31'd0, read0},  32'd0);
      check("rst_valid", {31'd0, valid0}, 32'd0);
      check("rst_an",    {28'd0, an0},    32'hE);
      check("rst_seg",   {25'd0, seg0},   {25'd0, DASH});
      check("rst_seg_b", {25'd0, seg1},   {25'd0, DASH});
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         exp_an = (k < 4) ? 4'b1110 : (k < 8) ? 4'b1101 : 4'b1011;
         check("idle_an",    {28'd0, an0},  {28'd0, exp_an});
         check("idle_dash",  {25'd0, seg0}, {25'd0, DASH});
         check("idle_dash_b", {25'd0, seg1}, {25'd0, DASH});
      end

      // 2 Capture 0x2ABCD with done held 5 cycles
      q_in = 18'h2ABCD;
      done = 1'b1;
      tick();
      check("cap_read",  {31'd0, read0},  32'd1);
      check("cap_valid", {31'd0, valid0}, 32'd1);
      check("cap_read_b", {31'd0, read1}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("cap_read_once", {31'd0, read0}, 32'd0);
      end

      // 3 done held, q_in changes: no recapture
      q_in = 18'h00010;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("held_no_read", {31'd0, read0}, 32'd0);
      end
      check("held_valid", {31'd0, valid0}, 32'd1);
      scan_check("disp_2abc",
                 {7'b0100100, 7'b0001000, 7'b0000011, 7'b1000110},
                 {7'b0100100, 7'b0001000, 7'b0000011, 7'b1000110});

      // 4 Second result after one done=0 cycle
      done = 1'b0;
      tick();
      check("gap_read", {31'd0, read0}, 32'd0);
      done = 1'b1;
      tick();
      check("cap2_read",   {31'd0, read0}, 32'd1);
      check("cap2_read_b", {31'd0, read1}, 32'd1);
      done = 1'b0;
      tick();
      check("cap2_read_drop", {31'd0, read0}, 32'd0);
      for (int i = 0; i < 4; i++) tick();
      scan_check("disp_0001",
                 {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111001},
                 {7'h7F, 7'h7F, 7'h7F, 7'b1111001});

      // 5 Reset in the ACK cycle
      done = 1'b1;
      tick();
      check("ack_read", {31'd0, read0}, 32'd1);
      rst = 1'b1;
      done = 1'b0;
      tick();
      check("mid_rst_read",  {31'd0, read0},  32'd0);
      check("mid_rst_valid", {31'd0, valid0}, 32'd0);
      check("mid_rst_an",    {28'd0, an0},    32'hE);
      check("mid_rst_seg",   {25'd0, seg0},   {25'd0, DASH});
      rst = 1'b0;
      tick();
      done = 1'b1;
      tick();
      check("post_rst_read",  {31'd0, read0},  32'd1);
      check("post_rst_valid", {31'd0, valid0}, 32'd1);
      done = 1'b0;
      tick();
      check("post_rst_drop", {31'd0, read0}, 32'd0);

      // 6 Scan timing on the blanking instance
      pa = an1;
      ps = seg1;
      seen = 1'b0;
      gap = 0;
      changes = 0;
      for (int i = 0; i < 24; i++) begin
         tick();
         gap++;
         check("an_onehot", $countones(~an1), 32'd1);
         if (an1 != pa) begin
            changes++;
            if (seen) check("an_period", gap, 32'd4);
            seen = 1'b1;
            gap = 0;
         end else begin
            check("seg_no_ghost", {25'd0, seg1}, {25'd0, ps});
         end
         pa = an1;
         ps = seg1;
      end
      check("an_changes", changes, 32'd6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
